// File: rtl/mx_rx_pkg.sv
// +----------------------------------------------------------------------+
// | mx_rx_pkg : shared state encoding and defaults for the Manchester RX |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mx_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_SFD  = 3'd2,
      ST_DATA = 3'd3,
      ST_ERR  = 3'd4
   } rx_state_t;

   localparam logic [7:0] SFD_DEFAULT = 8'hD0;

endpackage

`default_nettype wire

// File: rtl/mx_idle_timer.sv
// +----------------------------------------------------------------------+
// | mx_idle_timer : counts samp_clk ticks since the last bit pulse       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mx_idle_timer #(
   parameter int IDLE_SAMP = 24
) (
   input  logic clk,
   input  logic reset,
   input  logic samp_clk,
   input  logic clear,
   output logic timeout
);

   localparam int              c_TW  = $clog2(IDLE_SAMP + 1);
   localparam logic [c_TW-1:0] c_SAT = c_TW'(IDLE_SAMP);
   localparam logic [c_TW-1:0] c_ONE = c_TW'(1);

   logic [c_TW-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (samp_clk && (r_cnt != c_SAT)) begin
         r_cnt <= r_cnt + c_ONE;
      end
   end

   // Fires only on the tick that reaches saturation, so once per idle period
   assign timeout = samp_clk && !clear && (r_cnt == (c_SAT - c_ONE));

endmodule

`default_nettype wire

// File: rtl/mx_rx_ctrl.sv
// +----------------------------------------------------------------------+
// | mx_rx_ctrl : preamble/SFD/byte framing and host handshake for RX     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mx_rx_ctrl
   import mx_rx_pkg::*;
#(
   parameter int         NUM_SAMP  = 16,
   parameter int         IDLE_SAMP = NUM_SAMP + NUM_SAMP / 2,
   parameter int         PRE_BITS  = 16,
   parameter logic [7:0] SFD       = SFD_DEFAULT,
   parameter int         SFD_WIN   = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       samp_clk,
   input  logic       bit_zero,
   input  logic       bit_one,
   input  logic       data_ready,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       cardet,
   output logic       frame_done,
   output logic       error,
   output logic [2:0] state_dbg
);

   localparam int c_AW = $clog2(PRE_BITS + 1);
   localparam int c_WW = $clog2(SFD_WIN + 1);

   rx_state_t       r_state, w_state_nx;
   logic [c_AW-1:0] r_alt_cnt, w_alt_nx, w_alt_inc;
   logic [c_WW-1:0] r_win_cnt, w_win_nx;
   logic            r_last_bit, w_last_nx;
   logic [7:0]      r_sr, w_sr_nx, w_sr_shift;
   logic [2:0]      r_bit_cnt, w_bit_cnt_nx;
   logic [7:0]      r_data_out, w_data_out_nx;
   logic            r_data_valid, w_dv_nx;
   logic            r_cardet, w_cardet_nx;
   logic            r_frame_done, w_fd_nx;
   logic            r_error, w_err_nx;
   logic            w_to_err;
   logic            w_bit_evt, w_invalid, w_bit, w_timeout;

   assign w_bit_evt  = bit_zero ^ bit_one;
   assign w_invalid  = bit_zero & bit_one;
   assign w_bit      = bit_one;
   assign w_sr_shift = {w_bit, r_sr[7:1]};
   assign w_alt_inc  = r_alt_cnt + c_AW'(1);

   mx_idle_timer #(
      .IDLE_SAMP (IDLE_SAMP)
   ) u_idle_timer (
      .clk      (clk),
      .reset    (reset),
      .samp_clk (samp_clk),
      .clear    (bit_zero | bit_one),
      .timeout  (w_timeout)
   );

   always_comb begin
      w_state_nx    = r_state;
      w_alt_nx      = r_alt_cnt;
      w_win_nx      = r_win_cnt;
      w_last_nx     = r_last_bit;
      w_sr_nx       = r_sr;
      w_bit_cnt_nx  = r_bit_cnt;
      w_data_out_nx = r_data_out;
      w_dv_nx       = r_data_valid & ~data_ready;
      w_cardet_nx   = r_cardet;
      w_fd_nx       = 1'b0;
      w_err_nx      = 1'b0;
      w_to_err      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_cardet_nx = 1'b0;
            if (w_bit_evt) begin
               w_state_nx = ST_PRE;
               w_alt_nx   = c_AW'(1);
               w_last_nx  = w_bit;
            end
         end
         ST_PRE: begin
            if (w_timeout) begin
               w_state_nx = ST_IDLE;
            end else if (w_invalid) begin
               w_alt_nx = '0;
            end else if (w_bit_evt) begin
               w_last_nx = w_bit;
               w_alt_nx  = (w_bit != r_last_bit) ? w_alt_inc : c_AW'(1);
               if (w_alt_nx == c_AW'(PRE_BITS)) begin
                  w_state_nx  = ST_SFD;
                  w_cardet_nx = 1'b1;
                  w_sr_nx     = '0;
                  w_win_nx    = '0;
               end
            end
         end
         ST_SFD: begin
            if (w_timeout || w_invalid) begin
               w_to_err = 1'b1;
            end else if (w_bit_evt) begin
               w_sr_nx  = w_sr_shift;
               w_win_nx = r_win_cnt + c_WW'(1);
               if (w_sr_shift == SFD) begin
                  w_state_nx   = ST_DATA;
                  w_bit_cnt_nx = '0;
               end else if (w_win_nx == c_WW'(SFD_WIN)) begin
                  w_to_err = 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (w_invalid) begin
               w_to_err = 1'b1;
            end else if (w_bit_evt) begin
               w_sr_nx      = w_sr_shift;
               w_bit_cnt_nx = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) begin
                  // A still-pending byte means the host fell behind: drop the new one
                  if (r_data_valid && !data_ready) begin
                     w_to_err = 1'b1;
                  end else begin
                     w_data_out_nx = w_sr_shift;
                     w_dv_nx       = 1'b1;
                  end
               end
            end else if (w_timeout) begin
               if (r_bit_cnt == 3'd0) begin
                  w_state_nx  = ST_IDLE;
                  w_fd_nx     = 1'b1;
                  w_cardet_nx = 1'b0;
               end else begin
                  w_to_err = 1'b1;
               end
            end
         end
         ST_ERR: begin
            w_cardet_nx = 1'b0;
            if (w_timeout) begin
               w_state_nx = ST_IDLE;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase

      if (w_to_err) begin
         w_state_nx  = ST_ERR;
         w_err_nx    = 1'b1;
         w_cardet_nx = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_alt_cnt    <= '0;
         r_win_cnt    <= '0;
         r_last_bit   <= 1'b0;
         r_sr         <= '0;
         r_bit_cnt    <= '0;
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
         r_cardet     <= 1'b0;
         r_frame_done <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_alt_cnt    <= w_alt_nx;
         r_win_cnt    <= w_win_nx;
         r_last_bit   <= w_last_nx;
         r_sr         <= w_sr_nx;
         r_bit_cnt    <= w_bit_cnt_nx;
         r_data_out   <= w_data_out_nx;
         r_data_valid <= w_dv_nx;
         r_cardet     <= w_cardet_nx;
         r_frame_done <= w_fd_nx;
         r_error      <= w_err_nx;
      end
   end

   assign data_out   = r_data_out;
   assign data_valid = r_data_valid;
   assign cardet     = r_cardet;
   assign frame_done = r_frame_done;
   assign error      = r_error;
   assign state_dbg  = r_state;

endmodule

`default_nettype wire
